// File: rtl/serial_adder_if.sv
// Start/done handshake bundle for the bit-serial adder.
// The adder takes the slave side. The producer/consumer takes the master side.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic [WIDTH-1:0] sum_out;
  logic             cout;
  logic             ovf;
  logic             done_valid;
  logic             done_ready;
  logic             busy;

  modport master (
    output start_valid, a_in, b_in, cin, done_ready,
    input  start_ready, sum_out, cout, ovf, done_valid, busy
  );

  modport slave (
    input  start_valid, a_in, b_in, cin, done_ready,
    output start_ready, sum_out, cout, ovf, done_valid, busy
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder, LSB first. A single full-adder cell is reused over
// WIDTH cycles to form sum = a + b + cin. The block reports the unsigned carry
// out and the signed overflow.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sum_out_q;
  logic             cout_q, ovf_q;

  logic s_bit, c_next, last_bit, accept;

  // Full-adder cell on the current LSBs, plus handshake and last-bit qualifiers
  assign s_bit    = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_next   = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  assign accept   = (state_q == IDLE) && bus.start_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples
      // pre-edge values, whatever order the blocks are evaluated in.
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: state_d gets a default before the case. Any path left unassigned
    // would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_valid) state_d = RUN;
      RUN:     if (last_bit)        state_d = DONE;
      DONE:    if (bus.done_ready)  state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    bus.start_ready = (state_q == IDLE);
    bus.done_valid  = (state_q == DONE);
    bus.busy        = (state_q != IDLE);
  end

  // Datapath: operand capture, serial add, result hand-off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      sum_out_q <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.a_in;
      b_q     <= bus.b_in;
      carry_q <= bus.cin;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      sum_q   <= {s_bit, sum_q[WIDTH-1:1]};
      carry_q <= c_next;
      if (last_bit) begin
        // On the MSB edge carry_q holds the carry into the MSB. This is the
        // value left by the WIDTH-2 step, so no separate capture flop is used.
        sum_out_q <= {s_bit, sum_q[WIDTH-1:1]};
        cout_q    <= c_next;
        ovf_q     <= c_next ^ carry_q;
        cnt_q     <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.sum_out = sum_out_q;
  assign bus.cout    = cout_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder. A scoreboard queue holds the expected
// results. Directed checks cover latency, backpressure, operand hold and reset.
module tb_serial_adder;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [W-1:0] last_sum = '0;

  serial_adder_if #(.WIDTH(W)) ifc ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: compare every accepted result against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && ifc.done_valid && ifc.done_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_result", 1'b1, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        check("sum_out", ifc.sum_out, mon_e.sum);
        check("cout", ifc.cout, mon_e.cout);
        check("ovf", ifc.ovf, mon_e.ovf);
      end
    end
  end

  // One transaction. hold = cycles of done_ready low after done_valid rises.
  // scramble = change operands during RUN. keep_valid = leave start_valid high.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input int hold, input bit scramble, input bit keep_valid);
    exp_t       e;
    logic [W:0] full;
    int         n;
    n = 0;
    while (!ifc.start_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("start_ready_before_op", ifc.start_ready, 1'b1);
    ifc.a_in        = a;
    ifc.b_in        = b;
    ifc.cin         = ci;
    ifc.start_valid = 1'b1;
    ifc.done_ready  = (hold == 0);
    full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    @(posedge clk);
    sb.push_back(e);
    #1;
    if (!keep_valid) ifc.start_valid = 1'b0;
    check("busy_in_run", ifc.busy, 1'b1);
    check("start_ready_in_run", ifc.start_ready, 1'b0);
    check("sum_out_retained_in_run", ifc.sum_out, last_sum);
    n = 0;
    while (!ifc.done_valid && n < 4 * W) begin
      if (scramble) begin
        ifc.a_in = W'($urandom);
        ifc.b_in = W'($urandom);
        ifc.cin  = 1'($urandom);
      end
      @(posedge clk); #1; n++;
    end
    check("latency_edges", n, W);
    for (int i = 0; i < hold; i++) begin
      check("bp_done_valid", ifc.done_valid, 1'b1);
      check("bp_sum_out", ifc.sum_out, e.sum);
      check("bp_start_ready", ifc.start_ready, 1'b0);
      @(posedge clk); #1;
    end
    ifc.done_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_done_valid", ifc.done_valid, 1'b0);
    check("idle_start_ready", ifc.start_ready, 1'b1);
    check("idle_busy", ifc.busy, 1'b0);
    last_sum = e.sum;
  endtask

  initial begin
    rst_n           = 1'b0;
    ifc.start_valid = 1'b0;
    ifc.a_in        = '0;
    ifc.b_in        = '0;
    ifc.cin         = 1'b0;
    ifc.done_ready  = 1'b1;
    #3;
    check("rst_start_ready", ifc.start_ready, 1'b1);
    check("rst_done_valid", ifc.done_valid, 1'b0);
    check("rst_busy", ifc.busy, 1'b0);
    check("rst_sum_out", ifc.sum_out, '0);
    check("rst_cout", ifc.cout, 1'b0);
    check("rst_ovf", ifc.ovf, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic and boundary arithmetic
    run_op(8'h3C, 8'h15, 1'b0, 0, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 0, 1'b0, 1'b0);
    run_op(8'h80, 8'h80, 1'b0, 0, 1'b0, 1'b0);
    run_op(8'h0F, 8'hF0, 1'b1, 0, 1'b0, 1'b0);

    // Backpressure while start_valid stays high. The next op accepts after one IDLE cycle.
    run_op(8'hA5, 8'h5A, 1'b0, 5, 1'b0, 1'b1);
    run_op(8'h12, 8'h34, 1'b0, 0, 1'b0, 1'b0);

    // Operands changing during RUN must not disturb the result
    run_op(8'hC3, 8'h69, 1'b1, 0, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'b1, 1'b0);

    // Leave a non-zero result on sum_out before the reset test
    run_op(8'h00, 8'h00, 1'b1, 0, 1'b0, 1'b0);

    // Reset partway through a transaction
    ifc.a_in        = 8'h55;
    ifc.b_in        = 8'h33;
    ifc.cin         = 1'b0;
    ifc.start_valid = 1'b1;
    @(posedge clk); #1;
    ifc.start_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_done_valid", ifc.done_valid, 1'b0);
    check("midrst_sum_out", ifc.sum_out, '0);
    check("midrst_start_ready", ifc.start_ready, 1'b1);
    check("midrst_busy", ifc.busy, 1'b0);
    check("midrst_cout", ifc.cout, 1'b0);
    check("midrst_ovf", ifc.ovf, 1'b0);
    last_sum = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8'h55, 8'h33, 1'b0, 0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a hang if the DUT never responds
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
